// File: rtl/axis_stream_compare_checker.sv
// axis_stream_compare_checker
//
// Purpose: pulls a stream under test and an expected-data stream in lockstep,
// compares them word by word, checks the stream length (including the
// last-word marker) against EXPECTED_WORDS and guards against stalls with a
// watchdog. Results are held after completion for LED/ILA observation.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   i_start                single-cycle pulse that begins a check (IDLE/DONE only)
//   i_dut_data/valid/last  stream under test (AXI-Stream subset)
//   o_dut_ready            ready to the stream under test
//   i_ref_data/valid       expected stream
//   o_ref_ready            ready to the expected stream
//   o_busy                 high while a check is running
//   o_finished             check complete, status outputs valid
//   o_failed               any mismatch, length error or timeout
//   o_timeout              watchdog expired
//   o_length_error         last-word marker disagreed with EXPECTED_WORDS
//   o_word_count           words transferred
//   o_mismatch_count       mismatching words (saturating)
//   o_first_mismatch_idx   0-based index of first mismatch, all-ones if none
//   o_checksum             sum of accepted DUT words modulo 2^WIDTH
module axis_stream_compare_checker #(
  parameter int WIDTH          = 64,
  parameter int EXPECTED_WORDS = 841,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_dut_data,
  input  logic                 i_dut_valid,
  input  logic                 i_dut_last,
  output logic                 o_dut_ready,
  input  logic [WIDTH-1:0]     i_ref_data,
  input  logic                 i_ref_valid,
  output logic                 o_ref_ready,
  output logic                 o_busy,
  output logic                 o_finished,
  output logic                 o_failed,
  output logic                 o_timeout,
  output logic                 o_length_error,
  output logic [CNT_WIDTH-1:0] o_word_count,
  output logic [CNT_WIDTH-1:0] o_mismatch_count,
  output logic [CNT_WIDTH-1:0] o_first_mismatch_idx,
  output logic [WIDTH-1:0]     o_checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] EXP_CNT    = CNT_WIDTH'(EXPECTED_WORDS);
  localparam logic [CNT_WIDTH-1:0] IDLE_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ALL_ONES   = {CNT_WIDTH{1'b1}};

  state_t               r_state;
  logic                 r_busy;
  logic                 r_finished;
  logic                 r_failed;
  logic                 r_timeout;
  logic                 r_length_error;
  logic                 r_mismatch_seen;
  logic [CNT_WIDTH-1:0] r_word_count;
  logic [CNT_WIDTH-1:0] r_mismatch_count;
  logic [CNT_WIDTH-1:0] r_first_mismatch_idx;
  logic [CNT_WIDTH-1:0] r_idle_cnt;
  logic [WIDTH-1:0]     r_checksum;

  logic                 w_run;
  logic                 w_xfer;
  logic                 w_mis;
  logic [CNT_WIDTH-1:0] w_n;
  logic                 w_end;
  logic                 w_len_err;

  // Readies are gated by rst so nothing is consumed while reset is asserted,
  // even in the cycle before the state register falls back to IDLE.
  assign w_run       = (r_state == S_RUN) & ~rst;
  assign o_dut_ready = w_run & i_ref_valid;
  assign o_ref_ready = w_run & i_dut_valid;
  assign w_xfer      = w_run & i_dut_valid & i_ref_valid;

  assign w_mis     = (i_dut_data != i_ref_data);
  assign w_n       = r_word_count + 1'b1;
  // A stream ends either on its own last marker or when the expected count is
  // reached without one; in the latter case the overrun word is never taken.
  assign w_end     = i_dut_last | (w_n == EXP_CNT);
  assign w_len_err = i_dut_last ? (w_n != EXP_CNT) : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state              <= S_IDLE;
      r_busy               <= 1'b0;
      r_finished           <= 1'b0;
      r_failed             <= 1'b0;
      r_timeout            <= 1'b0;
      r_length_error       <= 1'b0;
      r_mismatch_seen      <= 1'b0;
      r_word_count         <= '0;
      r_mismatch_count     <= '0;
      r_first_mismatch_idx <= ALL_ONES;
      r_idle_cnt           <= '0;
      r_checksum           <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state              <= S_RUN;
            r_busy               <= 1'b1;
            r_finished           <= 1'b0;
            r_failed             <= 1'b0;
            r_timeout            <= 1'b0;
            r_length_error       <= 1'b0;
            r_mismatch_seen      <= 1'b0;
            r_word_count         <= '0;
            r_mismatch_count     <= '0;
            r_first_mismatch_idx <= ALL_ONES;
            r_idle_cnt           <= '0;
            r_checksum           <= '0;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_idle_cnt   <= '0;
            r_word_count <= w_n;
            r_checksum   <= r_checksum + i_dut_data;
            if (w_mis) begin
              r_mismatch_seen <= 1'b1;
              if (r_mismatch_count != ALL_ONES) begin
                r_mismatch_count <= r_mismatch_count + 1'b1;
              end
              if (!r_mismatch_seen) begin
                r_first_mismatch_idx <= r_word_count;
              end
            end
            if (w_end) begin
              r_state        <= S_DONE;
              r_busy         <= 1'b0;
              r_finished     <= 1'b1;
              r_length_error <= w_len_err;
              r_failed       <= r_mismatch_seen | w_mis | w_len_err;
            end
          end else if (r_idle_cnt == IDLE_LIMIT) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
            r_timeout  <= 1'b1;
            r_failed   <= 1'b1;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy               = r_busy;
  assign o_finished           = r_finished;
  assign o_failed             = r_failed;
  assign o_timeout            = r_timeout;
  assign o_length_error       = r_length_error;
  assign o_word_count         = r_word_count;
  assign o_mismatch_count     = r_mismatch_count;
  assign o_first_mismatch_idx = r_first_mismatch_idx;
  assign o_checksum           = r_checksum;

endmodule

// File: tb/tb_axis_stream_compare_checker.sv
// Testbench for axis_stream_compare_checker (WIDTH=8, EXPECTED_WORDS=4,
// TIMEOUT_CYCLES=10). Expected results come from a word-list model that walks
// the stimulus arrays and applies the termination and comparison rules.
module tb_axis_stream_compare_checker;

  localparam int EXP = 4;

  typedef struct packed {
    logic        finished;
    logic        failed;
    logic        timeout;
    logic        length_error;
    logic [31:0] wc;
    logic [31:0] mc;
    logic [31:0] fmi;
    logic [7:0]  cs;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_dut_data = '0;
  logic        i_dut_valid = 1'b0;
  logic        i_dut_last = 1'b0;
  logic        o_dut_ready;
  logic [7:0]  i_ref_data = '0;
  logic        i_ref_valid = 1'b0;
  logic        o_ref_ready;
  logic        o_busy, o_finished, o_failed, o_timeout, o_length_error;
  logic [31:0] o_word_count, o_mismatch_count, o_first_mismatch_idx;
  logic [7:0]  o_checksum;

  int checks = 0;
  int errors = 0;

  logic [7:0] dut_w [8];
  logic [7:0] ref_w [8];
  bit         last_w[8];
  int         nw;

  axis_stream_compare_checker #(
    .WIDTH(8), .EXPECTED_WORDS(4), .TIMEOUT_CYCLES(10), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_dut_data(i_dut_data), .i_dut_valid(i_dut_valid), .i_dut_last(i_dut_last),
    .o_dut_ready(o_dut_ready),
    .i_ref_data(i_ref_data), .i_ref_valid(i_ref_valid), .o_ref_ready(o_ref_ready),
    .o_busy(o_busy), .o_finished(o_finished), .o_failed(o_failed),
    .o_timeout(o_timeout), .o_length_error(o_length_error),
    .o_word_count(o_word_count), .o_mismatch_count(o_mismatch_count),
    .o_first_mismatch_idx(o_first_mismatch_idx), .o_checksum(o_checksum)
  );

  always #5 clk = ~clk;

  function automatic res_t observe();
    res_t r;
    r.finished = o_finished; r.failed = o_failed; r.timeout = o_timeout;
    r.length_error = o_length_error; r.wc = o_word_count; r.mc = o_mismatch_count;
    r.fmi = o_first_mismatch_idx; r.cs = o_checksum;
    return r;
  endfunction

  // Reference: walk the words the DUT stream offers; the stream stops on the
  // last marker or at EXP words, otherwise the watchdog must fire.
  function automatic res_t model();
    res_t r;
    bit done = 0;
    r = '0;
    r.fmi = '1;
    for (int i = 0; i < nw; i++) begin
      r.wc = i + 1;
      r.cs = r.cs + dut_w[i];
      if (dut_w[i] != ref_w[i]) begin
        r.mc = r.mc + 1;
        if (r.fmi == 32'hFFFF_FFFF) r.fmi = i;
      end
      if (last_w[i]) begin
        r.length_error = (i + 1 != EXP);
        done = 1;
        break;
      end
      if (i + 1 == EXP) begin
        r.length_error = 1;
        done = 1;
        break;
      end
    end
    if (!done) r.timeout = 1;
    r.finished = 1;
    r.failed = (r.mc != 0) || r.length_error || r.timeout;
    return r;
  endfunction

  task automatic load_pass();
    dut_w[0] = 8'h11; dut_w[1] = 8'h22; dut_w[2] = 8'h33; dut_w[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin ref_w[i] = dut_w[i]; last_w[i] = 0; end
    last_w[3] = 1;
    nw = 4;
  endtask

  task automatic do_start();
    @(negedge clk); i_start = 1;
    @(posedge clk); #1 i_start = 0;
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] r, input bit l);
    @(negedge clk);
    i_dut_valid = 1; i_ref_valid = 1; i_dut_data = d; i_ref_data = r; i_dut_last = l;
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    @(negedge clk);
    i_dut_valid = 0; i_ref_valid = 0; i_dut_last = 0;
  endtask

  // Streams the arrays with random valid gaps until finished or budget expires.
  task automatic drive(input int pd, input int pr, input int budget);
    int k = 0;
    int c = 0;
    bit x;
    forever begin
      @(negedge clk);
      if (o_finished) break;
      if (c >= budget) begin
        errors++; checks++;
        $display("FAIL drive_budget: finished=%0b after %0d cycles, required 1", o_finished, c);
        break;
      end
      c++;
      i_dut_valid = (k < nw) && ($urandom_range(0, 99) < pd);
      i_ref_valid = (k < nw) && ($urandom_range(0, 99) < pr);
      i_dut_data  = (k < nw) ? dut_w[k] : 8'($urandom);
      i_ref_data  = (k < nw) ? ref_w[k] : 8'($urandom);
      i_dut_last  = (k < nw) ? last_w[k] : 1'b0;
      #1;
      checks++;
      if ((o_dut_ready && !i_ref_valid) || (o_ref_ready && !i_dut_valid)) begin
        errors++;
        $display("FAIL ready_join: dut_ready=%0b ref_ready=%0b with dut_valid=%0b ref_valid=%0b",
                 o_dut_ready, o_ref_ready, i_dut_valid, i_ref_valid);
      end
      x = o_dut_ready && i_dut_valid;
      @(posedge clk);
      if (x) k++;
    end
    i_dut_valid = 0; i_ref_valid = 0; i_dut_last = 0;
  endtask

  task automatic test_reset();
    res_t exp_r, got;
    rst = 1; i_dut_valid = 1; i_ref_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    exp_r = '0; exp_r.fmi = '1;
    got = observe();
    checks++;
    if (got !== exp_r) begin errors++; $display("FAIL reset_status: got %h required %h", got, exp_r); end
    checks++;
    if ({o_busy, o_dut_ready, o_ref_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: busy/readies=%b required 000", {o_busy, o_dut_ready, o_ref_ready});
    end
    @(negedge clk); rst = 0; i_dut_valid = 0; i_ref_valid = 0;
    $display("test_reset done");
  endtask

  task automatic test_pass();
    res_t got, exp_r;
    load_pass();
    do_start();
    drive(100, 100, 50);
    got = observe(); exp_r = model();
    checks++;
    if (got !== exp_r) begin errors++; $display("FAIL pass_result: got %h required %h", got, exp_r); end
    checks++;
    if (got.cs !== 8'hAA || got.wc !== 32'd4 || got.fmi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL pass_const: cs=%h wc=%0d fmi=%h required AA 4 FFFFFFFF", got.cs, got.wc, got.fmi);
    end
    $display("test_pass: wc=%0d cs=%h failed=%0b", got.wc, got.cs, got.failed);
  endtask

  task automatic test_mismatch();
    res_t got, exp_r;
    load_pass(); dut_w[2] = 8'h30;
    do_start();
    drive(100, 100, 50);
    got = observe(); exp_r = model();
    checks++;
    if (got !== exp_r) begin errors++; $display("FAIL mismatch_result: got %h required %h", got, exp_r); end
    checks++;
    if (got.cs !== 8'hA7 || got.fmi !== 32'd2 || got.mc !== 32'd1 || got.failed !== 1'b1 || got.length_error !== 1'b0) begin
      errors++; $display("FAIL mismatch_const: cs=%h fmi=%0d mc=%0d failed=%0b le=%0b required A7 2 1 1 0",
                         got.cs, got.fmi, got.mc, got.failed, got.length_error);
    end
    $display("test_mismatch: fmi=%0d mc=%0d cs=%h", got.fmi, got.mc, got.cs);
  endtask

  task automatic test_length();
    res_t got, exp_r;
    // early last on word 1
    load_pass(); last_w[3] = 0; last_w[1] = 1;
    do_start();
    drive(100, 100, 50);
    got = observe(); exp_r = model();
    checks++;
    if (got !== exp_r || got.wc !== 32'd2 || got.length_error !== 1'b1) begin
      errors++; $display("FAIL length_early: got %h required %h", got, exp_r);
    end
    // no last at all; overrun words must stay unaccepted
    load_pass(); last_w[3] = 0; dut_w[4] = 8'h55; ref_w[4] = 8'h55; last_w[4] = 0; nw = 5;
    do_start();
    drive(100, 100, 50);
    got = observe(); exp_r = model();
    checks++;
    if (got !== exp_r || got.wc !== 32'd4 || got.length_error !== 1'b1) begin
      errors++; $display("FAIL length_missing: got %h required %h", got, exp_r);
    end
    i_dut_valid = 1; i_ref_valid = 1; i_dut_data = 8'h55; i_ref_data = 8'h55;
    #1;
    checks++;
    if ({o_dut_ready, o_ref_ready} !== 2'b00) begin
      errors++; $display("FAIL length_overrun_ready: readies=%b required 00", {o_dut_ready, o_ref_ready});
    end
    @(posedge clk); #1;
    checks++;
    if (o_word_count !== 32'd4 || o_checksum !== exp_r.cs) begin
      errors++; $display("FAIL length_overrun_hold: wc=%0d cs=%h required 4 %h", o_word_count, o_checksum, exp_r.cs);
    end
    quiet();
    $display("test_length done");
  endtask

  task automatic test_stall();
    res_t got, exp_r;
    // ref_valid toggling on the pass pattern
    load_pass();
    do_start();
    drive(100, 50, 200);
    got = observe(); exp_r = model();
    checks++;
    if (got !== exp_r) begin errors++; $display("FAIL stall_pass: got %h required %h", got, exp_r); end
    // random words, mismatches, last positions and gaps on both sides
    for (int t = 0; t < 20; t++) begin
      int lp;
      nw = $urandom_range(1, 7);
      lp = $urandom_range(0, 7);
      for (int i = 0; i < 8; i++) begin
        dut_w[i] = 8'($urandom);
        ref_w[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : dut_w[i];
        last_w[i] = (i == lp);
      end
      do_start();
      drive(70, 60, 300);
      got = observe(); exp_r = model();
      checks++;
      if (got !== exp_r) begin errors++; $display("FAIL stall_random[%0d]: got %h required %h", t, got, exp_r); end
      $display("test_stall[%0d]: nw=%0d last=%0d wc=%0d mc=%0d to=%0b", t, nw, lp, got.wc, got.mc, got.timeout);
    end
  endtask

  task automatic test_timeout();
    do_start();
    push(8'h11, 8'h11, 0);
    push(8'h22, 8'h22, 0);
    @(negedge clk); i_dut_valid = 0; i_ref_valid = 1;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early: timeout=%0b busy=%0b after 9 idle cycles, required 0 1", o_timeout, o_busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({o_timeout, o_finished, o_failed, o_busy, o_length_error} !== 5'b11100 || o_word_count !== 32'd2) begin
      errors++; $display("FAIL timeout_fire: to/fin/fail/busy/le=%b wc=%0d required 11100 2",
                         {o_timeout, o_finished, o_failed, o_busy, o_length_error}, o_word_count);
    end
    quiet();
    // xfer landing exactly at idle_cnt=9 wins over the watchdog
    do_start();
    push(8'h11, 8'h11, 0);
    push(8'h22, 8'h22, 0);
    @(negedge clk); i_dut_valid = 0; i_ref_valid = 0;
    repeat (9) @(posedge clk);
    push(8'h33, 8'h33, 0);
    checks++;
    if (o_timeout !== 1'b0 || o_busy !== 1'b1 || o_word_count !== 32'd3) begin
      errors++; $display("FAIL timeout_boundary: timeout=%0b busy=%0b wc=%0d required 0 1 3", o_timeout, o_busy, o_word_count);
    end
    push(8'h44, 8'h44, 1);
    checks++;
    if ({o_finished, o_failed, o_timeout} !== 3'b100 || o_checksum !== 8'hAA) begin
      errors++; $display("FAIL timeout_boundary_end: fin/fail/to=%b cs=%h required 100 AA", {o_finished, o_failed, o_timeout}, o_checksum);
    end
    quiet();
    $display("test_timeout done");
  endtask

  task automatic test_control();
    res_t got, exp_r;
    // start during RUN is ignored
    load_pass();
    do_start();
    push(8'h11, 8'h11, 0);
    push(8'h22, 8'h22, 0);
    @(negedge clk); i_dut_valid = 0; i_ref_valid = 0; i_start = 1;
    @(posedge clk); #1 i_start = 0;
    checks++;
    if (o_busy !== 1'b1 || o_word_count !== 32'd2 || o_checksum !== 8'h33) begin
      errors++; $display("FAIL start_in_run: busy=%0b wc=%0d cs=%h required 1 2 33", o_busy, o_word_count, o_checksum);
    end
    push(8'h33, 8'h33, 0);
    push(8'h44, 8'h44, 1);
    quiet();
    got = observe(); exp_r = model();
    checks++;
    if (got !== exp_r) begin errors++; $display("FAIL start_in_run_result: got %h required %h", got, exp_r); end
    // rst mid-RUN
    do_start();
    push(8'h11, 8'h10, 0);
    @(negedge clk); rst = 1; i_dut_valid = 1; i_ref_valid = 1;
    #1;
    checks++;
    if ({o_dut_ready, o_ref_ready} !== 2'b00) begin
      errors++; $display("FAIL rst_ready: readies=%b required 00", {o_dut_ready, o_ref_ready});
    end
    @(posedge clk); #1;
    exp_r = '0; exp_r.fmi = '1;
    got = observe();
    checks++;
    if (got !== exp_r || o_busy !== 1'b0 || {o_dut_ready, o_ref_ready} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_run: got %h busy=%0b required %h busy=0", got, o_busy, exp_r);
    end
    @(negedge clk); rst = 0; i_dut_valid = 0; i_ref_valid = 0;
    // rerun from DONE after a failing check
    load_pass(); dut_w[0] = 8'h01;
    do_start();
    drive(100, 100, 50);
    load_pass();
    do_start();
    checks++;
    if ({o_finished, o_failed, o_busy} !== 3'b001 || o_word_count !== 32'd0 || o_mismatch_count !== 32'd0 ||
        o_first_mismatch_idx !== 32'hFFFF_FFFF || o_checksum !== 8'h00) begin
      errors++; $display("FAIL rerun_clear: fin/fail/busy=%b wc=%0d mc=%0d fmi=%h cs=%h required 001 0 0 FFFFFFFF 00",
                         {o_finished, o_failed, o_busy}, o_word_count, o_mismatch_count, o_first_mismatch_idx, o_checksum);
    end
    drive(100, 100, 50);
    got = observe(); exp_r = model();
    checks++;
    if (got !== exp_r || got.cs !== 8'hAA) begin errors++; $display("FAIL rerun_result: got %h required %h", got, exp_r); end
    $display("test_control done");
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_length();
    test_stall();
    test_timeout();
    test_control();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
